// File: rtl/rx_buf_reader_if.sv
// Bus bundle for rx_buf_reader: buffer read port, commit handshake toward the
// frame writer, and the 64-bit valid/ready output stream.
//   commited_wr_address  writer's next free header slot (MAC clock domain)
//   rd_addr / rd_en      buffer read request, data returns one cycle later
//   rd_data              buffer read data
//   commited_rd_address  first unconsumed header slot, returned to the writer
//   rd_addr_updated      commit strobe
//   m_data/m_keep/m_last/m_valid/m_ready  output frame stream
// master = the reader block, slave = memory/writer/consumer side.
interface rx_buf_reader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] commited_wr_address;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [63:0]       rd_data;
    logic [ADDR_W-1:0] commited_rd_address;
    logic              rd_addr_updated;
    logic [63:0]       m_data;
    logic [7:0]        m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  commited_wr_address, rd_data, m_ready,
        output rd_addr, rd_en, commited_rd_address, rd_addr_updated,
               m_data, m_keep, m_last, m_valid
    );

    modport slave (
        output commited_wr_address, rd_data, m_ready,
        input  rd_addr, rd_en, commited_rd_address, rd_addr_updated,
               m_data, m_keep, m_last, m_valid
    );
endinterface

// File: rtl/rx_buf_reader.sv
// rx_buf_reader: read side of the Ethernet RX frame buffer. Waits for committed
// frames, reads each header (length in [63:32]) and its data words, streams the
// frame out through a small FIFO, then returns the consumed space to the writer.
// Ports:
//   clk, reset  250 MHz clock, synchronous active-high reset
//   bus         rx_buf_reader_if.master (memory read port, commit handshake,
//               output stream). rd_en/rd_addr are decoded from state so the
//               memory's own input register supplies the one-cycle latency.
// Optional: define RX_RD_STATS_EN to add saturating counters frames_out and
//   frames_skipped.
module rx_buf_reader #(
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned MAX_FRAME_BYTES = 9600,
    parameter int unsigned UPD_HOLD        = 4,
    parameter int unsigned OUT_DEPTH       = 4
) (
    input  logic            clk,
    input  logic            reset,
    rx_buf_reader_if.master bus
`ifdef RX_RD_STATS_EN
    ,
    output logic [31:0]     frames_out,
    output logic [31:0]     frames_skipped
`endif
);

    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH) + 1;
    localparam int unsigned WC_W   = 30;
    localparam int unsigned HOLD_W = $clog2(2 * UPD_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_SKIP,
        S_COMMIT
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } out_word_t;

    state_t            r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_wr_sync1, r_wr_sync2, r_wr_sync3, r_wr_ptr_s;
    logic [ADDR_W-1:0] r_rd_ptr, r_cmt_addr;
    logic              r_upd;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [2:0]        r_len_rem;
    logic [WC_W-1:0]   r_words, r_issued, r_pushed;
    logic              r_rd_pend;

    out_word_t         r_q [OUT_DEPTH];
    out_word_t         w_q_nxt [OUT_DEPTH];
    logic [CNT_W-1:0]  r_count, w_count_nxt, w_wr_idx;
    logic              r_m_valid;

    logic              w_frame_avail, w_room, w_can_commit;
    logic              w_rd_en, w_issue, w_commit;
    logic [ADDR_W-1:0] w_rd_addr, w_next_hdr;
    logic [31:0]       w_hdr_len;
    logic [WC_W-1:0]   w_hdr_words;
    logic              w_hdr_skip;
    logic              w_push, w_pop, w_last_push;
    logic [7:0]        w_last_keep;
    out_word_t         w_push_word;

    // Header decode and pointer arithmetic (wraps naturally mod 2^ADDR_W)
    assign w_frame_avail = (r_rd_ptr != r_wr_ptr_s);
    assign w_hdr_len     = bus.rd_data[63:32];
    assign w_hdr_words   = WC_W'((33'(w_hdr_len) + 33'd7) >> 3);
    assign w_hdr_skip    = (w_hdr_len == 32'd0) || (w_hdr_len > 32'(MAX_FRAME_BYTES));
    assign w_next_hdr    = r_rd_ptr + ADDR_W'(1) + ADDR_W'(r_words);
    assign w_room        = (r_count + CNT_W'(r_rd_pend)) < CNT_W'(OUT_DEPTH);
    assign w_can_commit  = (r_hold_cnt == '0);

    // Data word returning this cycle and whether it is the frame's last
    assign w_push      = r_rd_pend;
    assign w_last_push = r_rd_pend && ((r_pushed + WC_W'(1)) == r_words);
    assign w_pop       = r_m_valid && bus.m_ready;
    assign w_last_keep = (r_len_rem == 3'd0) ? 8'hFF : 8'((9'd1 << r_len_rem) - 9'd1);

    always_comb begin
        w_push_word.data = bus.rd_data;
        w_push_word.keep = w_last_push ? w_last_keep : 8'hFF;
        w_push_word.last = w_last_push;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and read-port requests
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        w_issue     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_frame_avail) begin
                    w_rd_en     = 1'b1;
                    w_rd_addr   = r_rd_ptr;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                w_state_nxt = w_hdr_skip ? S_SKIP : S_DATA;
            end
            S_DATA: begin
                // One read outstanding at most, and never more than the FIFO can take
                if ((r_issued != r_words) && w_room) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_rd_ptr + ADDR_W'(1) + ADDR_W'(r_issued);
                    w_issue   = 1'b1;
                end
                if (w_last_push) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_SKIP: begin
                w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                if (w_can_commit) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // CDC of the writer pointer, frame bookkeeping, commit and hold timing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_sync1 <= '0;
            r_wr_sync2 <= '0;
            r_wr_sync3 <= '0;
            r_wr_ptr_s <= '0;
            r_rd_ptr   <= '0;
            r_cmt_addr <= '0;
            r_upd      <= 1'b0;
            r_hold_cnt <= '0;
            r_len_rem  <= '0;
            r_words    <= '0;
            r_issued   <= '0;
            r_pushed   <= '0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_wr_sync1 <= bus.commited_wr_address;
            r_wr_sync2 <= r_wr_sync1;
            r_wr_sync3 <= r_wr_sync2;
            // Accept the pointer only once it has settled across two samples
            if (r_wr_sync2 == r_wr_sync3) begin
                r_wr_ptr_s <= r_wr_sync2;
            end

            if (r_state == S_HDR) begin
                r_len_rem <= w_hdr_len[2:0];
                r_words   <= w_hdr_words;
                r_issued  <= '0;
                r_pushed  <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + WC_W'(1);
                end
                if (w_push) begin
                    r_pushed <= r_pushed + WC_W'(1);
                end
            end
            r_rd_pend <= w_issue;

            // Hold counter spans UPD_HOLD strobe cycles plus UPD_HOLD quiet cycles
            if (w_commit) begin
                r_rd_ptr   <= w_next_hdr;
                r_cmt_addr <= w_next_hdr;
                r_hold_cnt <= HOLD_W'(2 * UPD_HOLD);
                r_upd      <= 1'b1;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                r_upd      <= (r_hold_cnt - HOLD_W'(1)) > HOLD_W'(UPD_HOLD);
            end
        end
    end

    // Shift-register FIFO: head always sits in slot 0
    always_comb begin
        for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
            w_q_nxt[i] = r_q[i];
        end
        if (w_pop) begin
            for (int unsigned i = 0; i < OUT_DEPTH - 1; i++) begin
                w_q_nxt[i] = r_q[i + 1];
            end
            w_q_nxt[OUT_DEPTH-1] = '0;
        end
        w_wr_idx = r_count - CNT_W'(w_pop);
        if (w_push) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                if (CNT_W'(i) == w_wr_idx) begin
                    w_q_nxt[i] = w_push_word;
                end
            end
        end
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count   <= '0;
            r_m_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                r_q[i] <= w_q_nxt[i];
            end
            r_count   <= w_count_nxt;
            r_m_valid <= (w_count_nxt != '0);
        end
    end

`ifdef RX_RD_STATS_EN
    logic [31:0] r_frames_out, r_frames_skipped;

    // Saturating frame counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frames_out     <= '0;
            r_frames_skipped <= '0;
        end else begin
            if (w_pop && r_q[0].last && (r_frames_out != '1)) begin
                r_frames_out <= r_frames_out + 32'd1;
            end
            if ((r_state == S_SKIP) && (r_frames_skipped != '1)) begin
                r_frames_skipped <= r_frames_skipped + 32'd1;
            end
        end
    end

    assign frames_out     = r_frames_out;
    assign frames_skipped = r_frames_skipped;
`endif

    assign bus.rd_en               = w_rd_en;
    assign bus.rd_addr             = w_rd_addr;
    assign bus.commited_rd_address = r_cmt_addr;
    assign bus.rd_addr_updated     = r_upd;
    assign bus.m_data              = r_q[0].data;
    assign bus.m_keep              = r_q[0].keep;
    assign bus.m_last              = r_q[0].last;
    assign bus.m_valid             = r_m_valid;

endmodule

// File: tb/tb_rx_buf_reader.sv
// Testbench for rx_buf_reader: behavioural buffer memory plus a frame-level
// reference model (expected word queue and expected commit-address queue).
module tb_rx_buf_reader;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned UPD_HOLD = 4;
    localparam int unsigned MAX_LEN  = 9600;
    localparam int unsigned MEM_D    = 1 << ADDR_W;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    rx_buf_reader_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef RX_RD_STATS_EN
    logic [31:0] frames_out, frames_skipped;
    int unsigned n_skipped_exp = 0;
    int unsigned n_frames_exp = 0;
`endif

    rx_buf_reader #(
        .ADDR_W         (ADDR_W),
        .MAX_FRAME_BYTES(MAX_LEN),
        .UPD_HOLD       (UPD_HOLD),
        .OUT_DEPTH      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef RX_RD_STATS_EN
        ,
        .frames_out    (frames_out),
        .frames_skipped(frames_skipped)
`endif
    );

    always #2 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0]       mem [MEM_D];
    word_t             exp_q[$];
    logic [ADDR_W-1:0] exp_cmt[$];
    logic [ADDR_W-1:0] wptr = '0;
    int                ready_mode = 0;

    // Buffer memory: registered read, one cycle latency
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lay a frame into the buffer and record what must come out of it
    task automatic add_frame(input int unsigned len);
        int unsigned w;
        logic [63:0] d;
        logic [7:0]  k;
        w = (len + 7) / 8;
        mem[wptr] = {len, $urandom()};
        if (len != 0 && len <= MAX_LEN) begin
            for (int unsigned i = 1; i <= w; i++) begin
                d = {$urandom(), $urandom()};
                mem[ADDR_W'(32'(wptr) + i)] = d;
                k = (i == w && (len % 8) != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
                exp_q.push_back('{data: d, keep: k, last: (i == w)});
            end
        end else begin
`ifdef RX_RD_STATS_EN
            n_skipped_exp++;
`endif
        end
        wptr = ADDR_W'(32'(wptr) + 1 + w);
        exp_cmt.push_back(wptr);
    endtask

    task automatic publish();
        bus.commited_wr_address = wptr;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_cmt.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check64({tag, "_drain"}, 64'(exp_q.size() + exp_cmt.size()), 64'(0));
        repeat (2 * UPD_HOLD + 2) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check64({tag, "_m_valid"}, 64'(bus.m_valid), 64'(0));
        check64({tag, "_m_data"},  bus.m_data,       64'(0));
        check64({tag, "_m_keep"},  64'(bus.m_keep),  64'(0));
        check64({tag, "_m_last"},  64'(bus.m_last),  64'(0));
        check64({tag, "_rd_en"},   64'(bus.rd_en),   64'(0));
        check64({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'(0));
        check64({tag, "_cmt_addr"}, 64'(bus.commited_rd_address), 64'(0));
        check64({tag, "_upd"},     64'(bus.rd_addr_updated), 64'(0));
    endtask

    // m_ready pattern generator
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.m_ready = ~bus.m_ready;
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Output stream and commit-handshake monitor
    int                hi_cnt = 0;
    int                post_cnt = 0;
    logic              prev_upd = 1'b0;
    logic [ADDR_W-1:0] ref_addr = '0;

    always @(negedge clk) begin
        word_t e;
        if (reset) begin
            prev_upd = 1'b0;
            hi_cnt   = 0;
            post_cnt = 0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check64("spurious_word", 64'(bus.m_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check64("m_data", bus.m_data, e.data);
                    check64("m_keep", 64'(bus.m_keep), 64'(e.keep));
                    check64("m_last", 64'(bus.m_last), 64'(e.last));
`ifdef RX_RD_STATS_EN
                    if (e.last) n_frames_exp++;
`endif
                end
            end
            if (bus.rd_addr_updated && !prev_upd) begin
                check64("commit_gap", 64'(post_cnt), 64'(0));
                if (exp_cmt.size() == 0) begin
                    check64("spurious_commit", 64'(bus.rd_addr_updated), 64'(0));
                end else begin
                    check64("commit_addr", 64'(bus.commited_rd_address), 64'(exp_cmt.pop_front()));
                end
                ref_addr = bus.commited_rd_address;
                hi_cnt   = 1;
            end else if (bus.rd_addr_updated) begin
                hi_cnt++;
                check64("addr_stable_hi", 64'(bus.commited_rd_address), 64'(ref_addr));
            end else if (prev_upd) begin
                check64("upd_width", 64'(hi_cnt), 64'(UPD_HOLD));
                check64("addr_stable_lo", 64'(bus.commited_rd_address), 64'(ref_addr));
                post_cnt = UPD_HOLD - 1;
            end else if (post_cnt > 0) begin
                check64("addr_stable_lo", 64'(bus.commited_rd_address), 64'(ref_addr));
                post_cnt--;
            end
            prev_upd = bus.rd_addr_updated;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wskip;
        for (int i = 0; i < int'(MEM_D); i++) mem[i] = '0;
        bus.rd_data = '0;
        bus.commited_wr_address = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_vals("reset");

        // Single 64-byte frame
        add_frame(64);
        publish();
        wait_done("f64", 300);
        check64("f64_cmt", 64'(bus.commited_rd_address), 64'(9));

        // Partial last word and single-word frame
        add_frame(61);
        add_frame(8);
        publish();
        wait_done("f61_f8", 300);
        check64("f61_f8_cmt", 64'(bus.commited_rd_address), 64'(20));

        // Back-pressure with m_ready toggling each cycle
        ready_mode = 1;
        add_frame(100);
        add_frame(60);
        publish();
        wait_done("bp", 600);

        // Random lengths under random back-pressure
        ready_mode = 2;
        for (int f = 0; f < 6; f++) add_frame($urandom_range(1, 300));
        publish();
        wait_done("rand", 3000);

        // Zero-length and oversize headers are skipped
        ready_mode = 0;
        add_frame(0);
        add_frame(20000);
        publish();
        wait_done("skip", 300);
        check64("skip_cmt", 64'(bus.commited_rd_address), 64'(wptr));

        // Oversize skip to land the next header at 1020, then read across the wrap
        wskip = 2048 + ((1019 + 1024 - 32'(wptr)) % 1024);
        add_frame(8 * wskip);
        add_frame(64);
        publish();
        wait_done("wrap", 400);
        check64("wrap_cmt", 64'(bus.commited_rd_address), 64'(5));
`ifdef RX_RD_STATS_EN
        check64("stats_skipped", 64'(frames_skipped), 64'(n_skipped_exp));
        check64("stats_out", 64'(frames_out), 64'(n_frames_exp));
`endif

        // Reset in the middle of a 1500-byte frame
        ready_mode = 2;
        add_frame(1500);
        publish();
        repeat (30) tick();
        reset = 1'b1;
        bus.commited_wr_address = '0;
        exp_q.delete();
        exp_cmt.delete();
        wptr = '0;
`ifdef RX_RD_STATS_EN
        n_skipped_exp = 0;
        n_frames_exp  = 0;
`endif
        tick();
        check_reset_vals("midreset");
        reset = 1'b0;
        repeat (20) tick();
        check64("post_reset_valid", 64'(bus.m_valid), 64'(0));
        check64("post_reset_cmt", 64'(bus.commited_rd_address), 64'(0));
`ifdef RX_RD_STATS_EN
        check64("post_reset_stats", 64'(frames_out), 64'(0));
`endif

        // Restart from address 0
        ready_mode = 0;
        add_frame(8);
        publish();
        wait_done("restart", 300);
        check64("restart_cmt", 64'(bus.commited_rd_address), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_buf_reader.md
Name: rx_buf_reader

Overview:
- Downstream consumer of the Ethernet RX frame buffer, on the read port of the internal dual-port memory.
- Waits for the write side to commit frames, then reads each frame's header word and data words.
- Emits each frame as a 64-bit valid/ready stream toward the DMA/TLP engine.
- Returns freed buffer space to the write side as a committed read address plus an update strobe.

Parameters:
- ADDR_W, 10: buffer word-address width; equals `BF+1.
- MAX_FRAME_BYTES, 9600: largest legal frame length in the header; longer frames are skipped.
- UPD_HOLD, 4: number of cycles rd_addr_updated stays high per commit.
- OUT_DEPTH, 4: output FIFO depth in words; must be a power of 2 and at least 2.

Ports:
- clk  in  1  250 MHz clock.
- reset  in  1  synchronous, active-high reset.
- commited_wr_address  in  ADDR_W  next free header slot; driven from the MAC (156.25 MHz) domain.
- rd_addr  out  ADDR_W  memory read address.
- rd_en  out  1  memory read enable; data returns 1 cycle later.
- rd_data  in  64  memory read data.
- commited_rd_address  out  ADDR_W  first unconsumed header slot.
- rd_addr_updated  out  1  commit strobe, held UPD_HOLD cycles.
- m_data  out  64  frame data.
- m_keep  out  8  byte enables, LSB-first.
- m_last  out  1  last word of frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.

Behaviour:
- Buffer format per frame:
  - header word at address H, frame length L in bits [63:32];
  - W = ceil(L/8) data words at H+1..H+W;
  - next header at H+1+W.
  - All address arithmetic is mod 2^ADDR_W.
- CDC of commited_wr_address:
  - two-flop synchroniser, then a stability filter;
  - wr_ptr_s updates only when two consecutive synchronised samples are equal.
- Frame available when rd_ptr != wr_ptr_s (rd_ptr is the internal header pointer).
- States:
  - IDLE: on frame available, issue header read (rd_en=1, rd_addr=rd_ptr), go to HDR.
  - HDR: capture L from rd_data[63:32].
    - L==0 or L>MAX_FRAME_BYTES: set W from L anyway, go to SKIP.
    - Otherwise go to DATA with word counter = W.
  - DATA: issue read of rd_ptr+1+n only when fifo_count + inflight < OUT_DEPTH (at most one in flight).
    - Returned word goes into the FIFO.
    - m_keep = 8'hFF except on the last word: low (L mod 8) bits set, or 8'hFF if L mod 8 = 0.
    - m_last = 1 on word W.
    - After word W is pushed, go to COMMIT.
  - SKIP: no reads, no output; go to COMMIT.
  - COMMIT: only if rd_addr_updated==0 and the hold gap has elapsed:
    - rd_ptr <= rd_ptr+1+W;
    - commited_rd_address <= rd_ptr+1+W;
    - next cycle rd_addr_updated=1 for exactly UPD_HOLD cycles;
    - go to IDLE.
- Commit rules:
  - commited_rd_address is stable whenever rd_addr_updated is high, and for UPD_HOLD cycles after it falls.
  - A further commit waits; the next frame may still be read meanwhile.
- Output FIFO:
  - m_valid = FIFO non-empty; pop on m_valid & m_ready;
  - push and pop in the same cycle leave the count unchanged;
  - no word is lost or duplicated under arbitrary m_ready patterns.
- Throughput: 1 word/cycle with m_ready held high, after a 2-cycle header overhead.
- Wrap: reads crossing address 2^ADDR_W-1 → 0 are handled by natural overflow.
- Reset values: rd_ptr=0, commited_rd_address=0, rd_addr_updated=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_keep=0, m_data=0, FIFO empty, state IDLE, wr_ptr_s=0.
- Reset mid-frame: output is discarded, nothing is committed, and reading restarts at address 0.
  - The writer must be reset together with this block.

Optional Feature:
- Macro RX_RD_STATS_EN.
- Defined:
  - adds outputs frames_out[31:0] (+1 on each accepted m_last word) and frames_skipped[31:0] (+1 on each SKIP entry);
  - both are saturating and reset to 0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- One 64-byte frame: header {32'd64,32'b0} at 0, data at 1..8, commited_wr_address=9, m_ready=1 -> 8 words out, all m_keep=FF, m_last on word 8; commited_rd_address=9; rd_addr_updated high 4 cycles.
- L=61 -> 8 words out, last m_keep=8'h1F; L=8 -> 1 word out, m_keep=FF, m_last=1.
- Back-pressure: 2 frames (L=100, L=60) with m_ready toggling 1/0 each cycle -> 13 then 8 words out in order, none lost; the second commit waits for the hold gap.
- Header at address 1020 (ADDR_W=10), L=64 -> data read from 1021,1022,1023,0..4; commited_rd_address=5.
- Header L=0, then a frame with L=20000 -> no output; pointer advances past both, 2 commits; frames_skipped=2 when RX_RD_STATS_EN is defined.
- Reset asserted mid-DATA of a 1500-byte frame -> all outputs at reset values the next cycle; commited_rd_address=0; no m_valid until a new commit arrives.
